// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: config port, timer done/ack pairs,
// external line and the CPU request/ack/return handshake.
interface int_ctrl_if;
    logic        cfg_we;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;
    logic        t0_done;
    logic        t1_done;
    logic        t0_ack;
    logic        t1_ack;
    logic        ext_int;
    logic        irq;
    logic [11:0] vector;
    logic        irq_ack;
    logic        reti;
    logic        in_service;

    modport slave (
        input  cfg_we, cfg_wdata, t0_done, t1_done,
        input  ext_int, irq_ack, reti,
        output cfg_rdata, t0_ack, t1_ack, irq, vector, in_service
    );

    modport master (
        output cfg_we, cfg_wdata, t0_done, t1_done,
        output ext_int, irq_ack, reti,
        input  cfg_rdata, t0_ack, t1_ack, irq, vector, in_service
    );
endinterface

// File: rtl/int_ctrl.sv
// Three-source fixed-priority interrupt controller (T0 > T1 > Ext)
// with a non-nesting IDLE/REQUEST/SERVICE handshake to the CPU.
module int_ctrl (
    input  logic       clk,
    input  logic       rst,
    int_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_SERVICE
    } state_e;

    state_e      state_q, state_d;
    logic        ext_s1_q, ext_s1_d;
    logic        ext_s2_q, ext_s2_d;
    logic        ext_s3_q, ext_s3_d;
    logic        t0_prev_q, t0_prev_d;
    logic        t1_prev_q, t1_prev_d;
    logic        gie_q, gie_d;
    logic [2:0]  ie_q, ie_d;
    logic [2:0]  if_q, if_d;
    logic [2:0]  src_q, src_d;
    logic [11:0] vector_q, vector_d;
    logic        irq_q, irq_d;
    logic        in_service_q, in_service_d;
    logic        t0_ack_q, t0_ack_d;
    logic        t1_ack_q, t1_ack_d;

    logic [2:0]  hw_set;
    logic        gie_w;
    logic [2:0]  ie_w;
    logic [2:0]  if_base;
    logic [2:0]  if_w;
    logic [2:0]  qual_q;
    logic [2:0]  qual_w;
    logic [2:0]  win;
    logic [11:0] win_vec;
    logic        unused_wdata3;

    assign unused_wdata3 = bus.cfg_wdata[3];

    // Bit order everywhere: [2] Ext, [1] T1, [0] T0
    always_comb begin
        ext_s1_d  = bus.ext_int;
        ext_s2_d  = ext_s1_q;
        ext_s3_d  = ext_s2_q;
        t0_prev_d = bus.t0_done;
        t1_prev_d = bus.t1_done;

        hw_set = {ext_s2_q & ~ext_s3_q,
                  bus.t1_done & ~t1_prev_q,
                  bus.t0_done & ~t0_prev_q};

        gie_w   = bus.cfg_we ? bus.cfg_wdata[7]   : gie_q;
        ie_w    = bus.cfg_we ? bus.cfg_wdata[6:4] : ie_q;
        if_base = bus.cfg_we ? bus.cfg_wdata[2:0] : if_q;
        if_w    = if_base | hw_set;

        qual_q = if_q & ie_q;
        qual_w = if_w & ie_w;
    end

    always_comb begin
        win = 3'b000;
        if (qual_q[0]) begin
            win = 3'b001;
        end else if (qual_q[1]) begin
            win = 3'b010;
        end else if (qual_q[2]) begin
            win = 3'b100;
        end

        win_vec = 12'h000;
        unique case (1'b1)
            win[0]:  win_vec = 12'h010;
            win[1]:  win_vec = 12'h020;
            win[2]:  win_vec = 12'h030;
            default: win_vec = 12'h000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        vector_d     = vector_q;
        irq_d        = irq_q;
        in_service_d = in_service_q;
        t0_ack_d     = 1'b0;
        t1_ack_d     = 1'b0;
        gie_d        = gie_w;
        ie_d         = ie_w;
        if_d         = if_w;

        unique case (state_q)
            S_IDLE: begin
                if (gie_q && (|qual_q)) begin
                    state_d  = S_REQUEST;
                    src_d    = win;
                    vector_d = win_vec;
                    irq_d    = 1'b1;
                end
            end
            S_REQUEST: begin
                if (bus.irq_ack) begin
                    state_d      = S_SERVICE;
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                    gie_d        = 1'b0;
                    // A fresh hardware event still wins over the ack clear
                    if_d         = (if_base & ~src_q) | hw_set;
                    t0_ack_d     = src_q[0];
                    t1_ack_d     = src_q[1];
                end else if (!(gie_w && (|(qual_w & src_q)))) begin
                    state_d = S_IDLE;
                    irq_d   = 1'b0;
                end
            end
            S_SERVICE: begin
                if (bus.reti) begin
                    state_d      = S_IDLE;
                    in_service_d = 1'b0;
                    gie_d        = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                irq_d        = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ext_s1_q     <= 1'b0;
            ext_s2_q     <= 1'b0;
            ext_s3_q     <= 1'b0;
            t0_prev_q    <= 1'b0;
            t1_prev_q    <= 1'b0;
            gie_q        <= 1'b0;
            ie_q         <= 3'b000;
            if_q         <= 3'b000;
            src_q        <= 3'b000;
            vector_q     <= 12'h000;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            t0_ack_q     <= 1'b0;
            t1_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ext_s1_q     <= ext_s1_d;
            ext_s2_q     <= ext_s2_d;
            ext_s3_q     <= ext_s3_d;
            t0_prev_q    <= t0_prev_d;
            t1_prev_q    <= t1_prev_d;
            gie_q        <= gie_d;
            ie_q         <= ie_d;
            if_q         <= if_d;
            src_q        <= src_d;
            vector_q     <= vector_d;
            irq_q        <= irq_d;
            in_service_q <= in_service_d;
            t0_ack_q     <= t0_ack_d;
            t1_ack_q     <= t1_ack_d;
        end
    end

    assign bus.cfg_rdata  = {gie_q, ie_q, 1'b0, if_q};
    assign bus.irq        = irq_q;
    assign bus.vector     = vector_q;
    assign bus.in_service = in_service_q;
    assign bus.t0_ack     = t0_ack_q;
    assign bus.t1_ack     = t1_ack_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed-vector bench for int_ctrl: one table row per clock,
// plus a hand-written external-interrupt latency sequence.
module tb_int_ctrl;

    logic clk;
    logic rst;

    int_ctrl_if bus ();

    int_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [7:0]  wd;
        logic        t0;
        logic        t1;
        logic        ext;
        logic        ack;
        logic        reti;
        logic        rst;
        logic [7:0]  rdata;
        logic        irq;
        logic [11:0] vec;
        logic        insvc;
        logic        a0;
        logic        a1;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    function automatic vec_t v(
        input logic we, input logic [7:0] wd,
        input logic t0, input logic t1, input logic ext,
        input logic ack, input logic reti, input logic r,
        input logic [7:0] rdata, input logic irq,
        input logic [11:0] vec, input logic insvc,
        input logic a0, input logic a1);
        vec_t x;
        x.we = we;       x.wd = wd;
        x.t0 = t0;       x.t1 = t1;     x.ext = ext;
        x.ack = ack;     x.reti = reti; x.rst = r;
        x.rdata = rdata; x.irq = irq;   x.vec = vec;
        x.insvc = insvc; x.a0 = a0;     x.a1 = a1;
        return x;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h",
                      nm, idx, act, exp);
    endtask

    task automatic idle_inputs();
        rst           = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_wdata = 8'h00;
        bus.t0_done   = 1'b0;
        bus.t1_done   = 1'b0;
        bus.ext_int   = 1'b0;
        bus.irq_ack   = 1'b0;
        bus.reti      = 1'b0;
    endtask

    initial begin
        int cyc;
        n_pass  = 0;
        n_total = 0;
        idle_inputs();

        //          we wd    t0 t1 ex ak rt rs  rdata irq vec     sv a0 a1
        // reset, then single T0 request / ack / reti / re-request
        vecs.push_back(v(0,8'h00,0,0,0,0,0,1, 8'h00,0,12'h000,0,0,0));
        vecs.push_back(v(1,8'h90,0,0,0,0,0,0, 8'h90,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,1,0,0,0,0,0, 8'h91,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'h91,1,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'h91,1,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,1,0,0, 8'h10,0,12'h010,1,1,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'h10,0,12'h010,1,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,1,0,0, 8'h10,0,12'h010,1,0,0));
        vecs.push_back(v(0,8'h00,1,0,0,0,0,0, 8'h11,0,12'h010,1,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,1,0, 8'h91,0,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'h91,1,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,1, 8'h00,0,12'h000,0,0,0));
        // simultaneous T0/T1, reti re-arbitration, reset in SERVICE
        vecs.push_back(v(1,8'hF0,0,0,0,0,0,0, 8'hF0,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,1,1,0,0,0,0, 8'hF3,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'hF3,1,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,1,0,0, 8'h72,0,12'h010,1,1,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,1,0, 8'hF2,0,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'hF2,1,12'h020,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,1,0,0, 8'h70,0,12'h020,1,0,1));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,1, 8'h00,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,1,0,0, 8'h00,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,1,0, 8'h00,0,12'h000,0,0,0));
        // external line through the synchronizer
        vecs.push_back(v(1,8'hC0,0,0,0,0,0,0, 8'hC0,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,1,0,0,0, 8'hC0,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,1,0,0,0, 8'hC0,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,1,0,0,0, 8'hC4,0,12'h000,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,1,0,0,0, 8'hC4,1,12'h030,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,1,0,0, 8'h40,0,12'h030,1,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,1,0, 8'hC0,0,12'h030,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'hC0,0,12'h030,0,0,0));
        // cancel in REQUEST, stray ack, hw set beats sw clear
        vecs.push_back(v(1,8'h90,0,0,0,0,0,0, 8'h90,0,12'h030,0,0,0));
        vecs.push_back(v(0,8'h00,1,0,0,0,0,0, 8'h91,0,12'h030,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'h91,1,12'h010,0,0,0));
        vecs.push_back(v(1,8'h11,0,0,0,0,0,0, 8'h11,0,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,1,0,0, 8'h11,0,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'h11,0,12'h010,0,0,0));
        vecs.push_back(v(1,8'h10,1,0,0,0,0,0, 8'h11,0,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'h11,0,12'h010,0,0,0));
        // higher-priority arrival during REQUEST keeps the winner
        vecs.push_back(v(1,8'hF0,0,0,0,0,0,0, 8'hF0,0,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,1,0,0,0,0, 8'hF2,0,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'hF2,1,12'h020,0,0,0));
        vecs.push_back(v(0,8'h00,1,0,0,0,0,0, 8'hF3,1,12'h020,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,1,0,0, 8'h71,0,12'h020,1,0,1));
        vecs.push_back(v(0,8'h00,0,0,0,0,1,0, 8'hF1,0,12'h020,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,0, 8'hF1,1,12'h010,0,0,0));
        vecs.push_back(v(0,8'h00,0,0,0,0,0,1, 8'h00,0,12'h000,0,0,0));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].rst;
            bus.cfg_we    = vecs[i].we;
            bus.cfg_wdata = vecs[i].wd;
            bus.t0_done   = vecs[i].t0;
            bus.t1_done   = vecs[i].t1;
            bus.ext_int   = vecs[i].ext;
            bus.irq_ack   = vecs[i].ack;
            bus.reti      = vecs[i].reti;
            @(posedge clk);
            #1;
            chk("rdata",  i, {4'h0, bus.cfg_rdata}, {4'h0, vecs[i].rdata});
            chk("irq",    i, {11'h0, bus.irq},      {11'h0, vecs[i].irq});
            chk("vector", i, bus.vector,            vecs[i].vec);
            chk("in_svc", i, {11'h0, bus.in_service}, {11'h0, vecs[i].insvc});
            chk("t0_ack", i, {11'h0, bus.t0_ack},   {11'h0, vecs[i].a0});
            chk("t1_ack", i, {11'h0, bus.t1_ack},   {11'h0, vecs[i].a1});
        end

        // ext_int rising between edges: ExtIF on 3rd edge, irq on 4th
        idle_inputs();
        bus.cfg_we    = 1'b1;
        bus.cfg_wdata = 8'hC0;
        @(posedge clk);
        #1;
        idle_inputs();
        #2;
        bus.ext_int = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            if (c == 3) chk("hs_extif", c, {4'h0, bus.cfg_rdata}, 12'h0C4);
            if (bus.irq) break;
            if (c == 10) cyc = 11;
        end
        chk("hs_irq_lat", 0, cyc[11:0], 12'd4);
        chk("hs_vector",  0, bus.vector, 12'h030);

        bus.irq_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.irq_ack = 1'b0;
        chk("hs_in_svc", 0, {11'h0, bus.in_service}, 12'h001);
        chk("hs_acks",   0, {10'h0, bus.t1_ack, bus.t0_ack}, 12'h000);
        chk("hs_rdata",  0, {4'h0, bus.cfg_rdata}, 12'h040);
        chk("hs_irq",    0, {11'h0, bus.irq}, 12'h000);

        bus.reti = 1'b1;
        @(posedge clk);
        #1;
        bus.reti = 1'b0;
        chk("hs_reti_svc", 0, {11'h0, bus.in_service}, 12'h000);
        chk("hs_reti_cfg", 0, {4'h0, bus.cfg_rdata}, 12'h0C0);
        @(posedge clk);
        #1;
        chk("hs_no_rearm", 0, {11'h0, bus.irq}, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all logic on rising edge; rst  in  1  reset, synchronous, active-high.
REQ-002 The block SHALL have ports: cfg_we  in  1  write strobe; cfg_wdata  in  8  write data; cfg_rdata  out  8  cpu_cfg readback.
REQ-003 The cpu_cfg bit layout SHALL be: [7] GIE, [6] ExtIE, [5] T1IE, [4] T0IE, [3] reads 0, [2] ExtIF, [1] T1IF, [0] T0IF.
REQ-004 The block SHALL have ports: t0_done  in  1  timer0 done level; t1_done  in  1  timer1 done level; t0_ack  out  1  timer0 done_ack pulse; t1_ack  out  1  timer1 done_ack pulse.
REQ-005 The block SHALL have port: ext_int  in  1  asynchronous external interrupt line.
REQ-006 The block SHALL have ports: irq  out  1  request to CPU; vector  out  12  target address; irq_ack  in  1  CPU accepted request at instruction boundary; reti  in  1  CPU executed return-from-interrupt; in_service  out  1  handler active.

Function
REQ-007 ext_int SHALL pass a 2-flop synchronizer plus an edge-detect flop; a synchronized rising edge SHALL set ExtIF at the 3rd rising clk edge after ext_int rises.
REQ-008 A rising edge of t0_done (t1_done), detected against a registered copy, SHALL set T0IF (T1IF) on the edge where t0_done is first seen high.
REQ-009 A cfg_we cycle SHALL load all bits of cpu_cfg except bit 3; a hardware set of an IF bit in the same cycle SHALL win over a software write of 0.
REQ-010 Qualified source = IF & IE. Fixed priority SHALL be T0 > T1 > Ext.
REQ-011 The FSM SHALL have states IDLE, REQUEST and SERVICE.
REQ-012 IDLE -> REQUEST on the edge where GIE=1 and any qualified source exists; the winning source SHALL be latched, with vector set to T0=12'h010, T1=12'h020, Ext=12'h030.
REQ-013 irq SHALL be 1 only in REQUEST; vector SHALL be held stable throughout REQUEST and SERVICE.
REQ-014 REQUEST -> SERVICE on irq_ack=1. On that edge the block SHALL: clear the latched source's IF; clear GIE; issue a one-cycle t0_ack/t1_ack pulse (next cycle) when the source is a timer.
REQ-015 REQUEST -> IDLE, without ack, if GIE or the latched source's IE/IF is cleared by cfg_we before irq_ack; irq SHALL drop on the following cycle.
REQ-016 In SERVICE, in_service SHALL be 1 and no new request SHALL be raised (no nesting); sources SHALL keep latching IF bits.
REQ-017 SERVICE -> IDLE on reti=1, setting GIE=1 on the same edge; pending qualified sources then re-arbitrate from IDLE.
REQ-018 irq_ack outside REQUEST and reti outside SERVICE SHALL be ignored.
REQ-019 Sources arriving while in REQUEST SHALL NOT change the latched winner or vector.
REQ-020 Latency from qualified IF visible (with GIE=1) to irq=1 SHALL be exactly 1 clock.

Reset
REQ-021 On rst=1, state SHALL go to IDLE; cpu_cfg, synchronizer/edge flops and the latched source SHALL be cleared; irq=0, t0_ack=0, t1_ack=0, in_service=0, vector=12'h000, cfg_rdata=8'h00.
REQ-022 rst SHALL take precedence over all other inputs, including mid-REQUEST or mid-SERVICE; the interrupted handler's flags are lost.

Verification
REQ-023 Test: cfg=8'h90, t0_done pulses high. Required: T0IF=1, then irq=1 with vector=12'h010; after irq_ack, cfg_rdata=8'h10, t0_ack pulses once, in_service=1.
REQ-024 Test: cfg=8'hF0, t0_done and t1_done rise on the same edge. Required: vector=12'h010 first; after ack and reti, a second request with vector=12'h020.
REQ-025 Test: cfg=8'hC0, ext_int rises. Required: ExtIF set at the 3rd edge; irq follows 1 clock later; vector=12'h030.
REQ-026 Test: in SERVICE with T1 pending, assert reti. Required: GIE=1, state IDLE, irq=1 one clock later, vector=12'h020.
REQ-027 Test: in REQUEST, cfg_we writes GIE=0. Required: irq deasserts, IF remains set, no t0_ack/t1_ack.
REQ-028 Test: assert rst during SERVICE. Required: all outputs at reset values on the next edge; a later irq_ack or reti has no effect.
